// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo : parametrised UART receiver feeding a show-ahead RX FIFO. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 2604,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        sys_rst_n,
    input  logic                        uart_rx,
    input  logic                        rd_en,
    input  logic                        clr_err,
    output logic [DATA_BITS-1:0]        rx_data,
    output logic                        rx_empty,
    output logic                        rx_full,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        frame_err,
    output logic                        parity_err,
    output logic                        overrun,
    output logic                        busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] C_MID   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] C_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] C_DLAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] C_SLAST = BW'(STOP_BITS - 1);
    localparam logic          C_ODD   = (PARITY == 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic                 sync1_q, sync2_q, rx_s;
    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 sbad_q, sbad_d;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          count_q;
    logic                 frame_err_q, parity_err_q, overrun_q;

    logic bit_end, stop_sample, frame_ok, push_req, push, pop, full;
    logic set_ferr, set_perr, set_ovr;

    assign rx_s    = sync2_q;
    assign bit_end = (cnt_q == C_LAST);
    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));

    // State register and receive datapath
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            perr_q   <= 1'b0;
            sbad_q   <= 1'b0;
        end else begin
            sync1_q  <= uart_rx;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            perr_q   <= perr_d;
            sbad_q   <= sbad_d;
        end
    end

    // Next-state logic; the baud counter restarts on every state change
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        perr_d   = perr_q;
        sbad_d   = sbad_q;
        case (state_q)
            S_IDLE: begin
                cnt_d    = '0;
                bitcnt_d = '0;
                perr_d   = 1'b0;
                sbad_d   = 1'b0;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == C_MID) begin
                    cnt_d   = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    shift_d  = {rx_s, shift_q[DATA_BITS-1:1]};
                    bitcnt_d = bitcnt_q + BW'(1);
                    if (bitcnt_q == C_DLAST) begin
                        bitcnt_d = '0;
                        state_d  = (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    perr_d  = (^shift_q) ^ rx_s ^ C_ODD;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    bitcnt_d = bitcnt_q + BW'(1);
                    if (!rx_s) sbad_d = 1'b1;
                    if (bitcnt_q == C_SLAST) begin
                        bitcnt_d = '0;
                        state_d  = (sbad_q || !rx_s) ? S_BREAK : S_IDLE;
                    end
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rx_s) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode: frame disposition and status
    always_comb begin
        stop_sample = (state_q == S_STOP) && bit_end;
        frame_ok    = stop_sample && (bitcnt_q == C_SLAST) && rx_s && !sbad_q;
        push_req    = frame_ok && !perr_q;
        push        = push_req && (!full || rd_en);
        set_ferr    = stop_sample && !rx_s;
        set_perr    = frame_ok && perr_q;
        set_ovr     = push_req && full && !rd_en;
        busy        = (state_q != S_IDLE);
    end

    assign pop = rd_en && (count_q != '0);

    // A push into a full FIFO alongside a pop lands in the slot being freed
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_err_q  <= set_ferr | (frame_err_q  & ~clr_err);
            parity_err_q <= set_perr | (parity_err_q & ~clr_err);
            overrun_q    <= set_ovr  | (overrun_q    & ~clr_err);
        end
    end

    assign rx_data    = mem_q[rd_ptr_q];
    assign rx_empty   = (count_q == '0);
    assign rx_full    = full;
    assign fifo_count = count_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo : directed bench for uart_rx_fifo (8N1 and 8E1 instances). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_fifo;
    localparam int C     = 16;
    localparam int DEPTH = 4;
    localparam int K_OK = 0, K_PERR = 1, K_FERR = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       rx  [2];
    logic       rd  [2];
    logic       clr [2];
    logic [7:0] d_data [2];
    logic       d_empty[2], d_full[2], d_ferr[2], d_perr[2], d_ovr[2], d_busy[2];
    logic [2:0] d_cnt [2];

    uart_rx_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u0 (
        .clk(clk), .sys_rst_n(rst_n), .uart_rx(rx[0]), .rd_en(rd[0]), .clr_err(clr[0]),
        .rx_data(d_data[0]), .rx_empty(d_empty[0]), .rx_full(d_full[0]), .fifo_count(d_cnt[0]),
        .frame_err(d_ferr[0]), .parity_err(d_perr[0]), .overrun(d_ovr[0]), .busy(d_busy[0]));

    uart_rx_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u1 (
        .clk(clk), .sys_rst_n(rst_n), .uart_rx(rx[1]), .rd_en(rd[1]), .clr_err(clr[1]),
        .rx_data(d_data[1]), .rx_empty(d_empty[1]), .rx_full(d_full[1]), .fifo_count(d_cnt[1]),
        .frame_err(d_ferr[1]), .parity_err(d_perr[1]), .overrun(d_ovr[1]), .busy(d_busy[1]));

    // Behavioural model: a character queue plus sticky flags per instance
    logic [7:0] mq [2][$];
    bit         m_ferr[2], m_perr[2], m_ovr[2];
    bit         pv[2];
    int         pe[2], pk[2];
    logic [7:0] pd[2];
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;

    // Frames resolve on the edge that samples the last stop bit
    always @(posedge clk) begin
        bit was_full, popping;
        cyc++;
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                was_full = (mq[d].size() == DEPTH);
                popping  = rd[d] && (mq[d].size() > 0);
                if (clr[d]) begin
                    m_ferr[d] = 0; m_perr[d] = 0; m_ovr[d] = 0;
                end
                if (popping) mq[d].delete(0);
                if (pv[d] && cyc == pe[d]) begin
                    pv[d] = 0;
                    if (pk[d] == K_FERR)              m_ferr[d] = 1;
                    else if (pk[d] == K_PERR)         m_perr[d] = 1;
                    else if (was_full && !rd[d])      m_ovr[d]  = 1;
                    else                              mq[d].push_back(pd[d]);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] head;
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                head = (mq[d].size() > 0) ? mq[d][0] : 8'h00;
                checks++;
                if (d_empty[d] !== (mq[d].size() == 0) || d_full[d] !== (mq[d].size() == DEPTH) ||
                    d_cnt[d] !== 3'(mq[d].size()) || d_ferr[d] !== m_ferr[d] ||
                    d_perr[d] !== m_perr[d] || d_ovr[d] !== m_ovr[d] ||
                    (mq[d].size() > 0 && d_data[d] !== head)) begin
                    errors++;
                    if (errors < 20)
                        $display("FAIL model_cmp u%0d cyc %0d: got cnt=%0d empty=%b full=%b data=%h fe=%b pe=%b ov=%b, want cnt=%0d head=%h fe=%b pe=%b ov=%b",
                                 d, cyc, d_cnt[d], d_empty[d], d_full[d], d_data[d], d_ferr[d], d_perr[d], d_ovr[d],
                                 mq[d].size(), head, m_ferr[d], m_perr[d], m_ovr[d]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_pending(input int d);
        for (int n = 0; n < 4000 && pv[d]; n++) tick(1);
        chk("frame_resolved", {31'd0, pv[d]}, 0);
    endtask

    // Drive one frame; hold_low extends a low stop bit into a line break
    task automatic send(input int d, input logic [7:0] v, input logic pbit, input logic sbit, input int hold_low);
        int p;
        p = (d == 1) ? 1 : 0;
        @(posedge clk); #1;
        pd[d] = v;
        pe[d] = cyc + 3 + C/2 + C*(9 + p);
        if (!sbit)                          pk[d] = K_FERR;
        else if (p == 1 && ((^v) ^ pbit))   pk[d] = K_PERR;
        else                                pk[d] = K_OK;
        pv[d] = 1;
        rx[d] = 1'b0; tick(C);
        for (int i = 0; i < 8; i++) begin rx[d] = v[i]; tick(C); end
        if (p == 1) begin rx[d] = pbit; tick(C); end
        rx[d] = sbit; tick(C + hold_low);
        if (hold_low > 0) chk("break_busy", {31'd0, d_busy[d]}, 1);
        rx[d] = 1'b1;
        wait_pending(d);
        tick(4*C);
        chk("idle_busy", {31'd0, d_busy[d]}, 0);
    endtask

    task automatic pop(input int d, input logic [7:0] exp, input string name);
        chk(name, {24'd0, d_data[d]}, {24'd0, exp});
        rd[d] = 1'b1; tick(1); rd[d] = 1'b0;
    endtask

    task automatic clear_err(input int d);
        clr[d] = 1'b1; tick(1); clr[d] = 1'b0;
    endtask

    task automatic pop_at_stop(input int d);
        int n;
        @(posedge clk); #2;
        n = 0;
        while (!pv[d] && n < 50) begin tick(1); n++; end
        n = 0;
        while (cyc < pe[d] - 1 && n < 4000) begin tick(1); n++; end
        chk("pop_on_stop_cycle", cyc, pe[d] - 1);
        rd[d] = 1'b1; tick(1); rd[d] = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_empty"}, {31'd0, d_empty[d]}, 1);
            chk({tag, "_full"},  {31'd0, d_full[d]},  0);
            chk({tag, "_count"}, {29'd0, d_cnt[d]},   0);
            chk({tag, "_data"},  {24'd0, d_data[d]},  0);
            chk({tag, "_flags"}, {28'd0, d_ferr[d], d_perr[d], d_ovr[d], d_busy[d]}, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin rx[d] = 1'b1; rd[d] = 1'b0; clr[d] = 1'b0; end
        tick(20);
        reset_checks("reset");
        rst_n = 1'b1;
        tick(C);

        // Basic reception and in-order pops
        send(0, 8'hA5, 0, 1, 0); chk("cnt_after_A5", {29'd0, d_cnt[0]}, 1);
        send(0, 8'hE7, 0, 1, 0); chk("cnt_after_E7", {29'd0, d_cnt[0]}, 2);
        send(0, 8'h24, 0, 1, 0); chk("cnt_after_24", {29'd0, d_cnt[0]}, 3);
        pop(0, 8'hA5, "pop_A5"); pop(0, 8'hE7, "pop_E7"); pop(0, 8'h24, "pop_24");
        chk("empty_after_pops", {31'd0, d_empty[0]}, 1);

        // Short low glitch is rejected at the start mid-sample
        rx[0] = 1'b0; tick(4);
        chk("glitch_busy", {31'd0, d_busy[0]}, 1);
        rx[0] = 1'b1; tick(20);
        chk("glitch_idle", {31'd0, d_busy[0]}, 0);
        chk("glitch_nopush", {29'd0, d_cnt[0]}, 0);

        // Framing error followed by a line break, then recovery
        send(0, 8'hA5, 0, 0, 3*C);
        chk("ferr_set", {31'd0, d_ferr[0]}, 1);
        send(0, 8'h3C, 0, 1, 0);
        pop(0, 8'h3C, "pop_3C");
        clear_err(0);
        chk("ferr_cleared", {31'd0, d_ferr[0]}, 0);

        // Even parity: correct then wrong parity bit
        send(1, 8'h07, 1, 1, 0);
        chk("par_ok_cnt", {29'd0, d_cnt[1]}, 1);
        chk("par_ok_flag", {31'd0, d_perr[1]}, 0);
        send(1, 8'h07, 0, 1, 0);
        chk("par_bad_flag", {31'd0, d_perr[1]}, 1);
        chk("par_bad_cnt", {29'd0, d_cnt[1]}, 1);
        pop(1, 8'h07, "pop_07");

        // Overrun and pointer wrap
        send(0, 8'h11, 0, 1, 0); send(0, 8'h22, 0, 1, 0); send(0, 8'h33, 0, 1, 0);
        send(0, 8'h44, 0, 1, 0); send(0, 8'h55, 0, 1, 0);
        chk("ovr_full", {31'd0, d_full[0]}, 1);
        chk("ovr_flag", {31'd0, d_ovr[0]}, 1);
        pop(0, 8'h11, "pop_11"); pop(0, 8'h22, "pop_22");
        send(0, 8'h66, 0, 1, 0); send(0, 8'h77, 0, 1, 0);
        pop(0, 8'h33, "pop_33"); pop(0, 8'h44, "pop_44");
        send(0, 8'h88, 0, 1, 0); send(0, 8'h99, 0, 1, 0);
        chk("wrap_full_head", {24'd0, d_data[0]}, 32'h66);
        clear_err(0);

        // Full FIFO with a pop on the final stop-sample cycle
        fork
            send(0, 8'hAA, 0, 1, 0);
            pop_at_stop(0);
        join
        chk("fullpop_cnt", {29'd0, d_cnt[0]}, 4);
        chk("fullpop_ovr", {31'd0, d_ovr[0]}, 0);
        pop(0, 8'h77, "pop_77"); pop(0, 8'h88, "pop_88"); pop(0, 8'h99, "pop_99");

        // Reset asserted during data bit 4 discards everything
        rx[0] = 1'b0; tick(C);
        for (int i = 0; i < 4; i++) begin rx[0] = (8'h5A >> i) & 1; tick(C); end
        rx[0] = 1'b1; tick(C/2);
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            mq[d].delete(); m_ferr[d] = 0; m_perr[d] = 0; m_ovr[d] = 0; pv[d] = 0;
        end
        tick(5);
        reset_checks("midreset");
        rst_n = 1'b1;
        tick(C);
        send(0, 8'hC3, 0, 1, 0);
        chk("post_reset_cnt", {29'd0, d_cnt[0]}, 1);
        pop(0, 8'hC3, "pop_C3");
        tick(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver with a receive FIFO. It replaces the fixed 8N1 receive path on the snn top level. It supports configurable baud divisor, data width, parity and stop bits. Received characters are buffered in a show-ahead FIFO that the consumer pops with a read strobe, and framing, parity and overrun errors are reported as sticky flags.

Parameters:
CLKS_PER_BIT, 2604, clk cycles per bit (100 MHz / 38400 baud); legal range is 4 or more.
DATA_BITS, 8, data bits per frame, LSB first; range 5..9.
PARITY, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, 1 or 2.
FIFO_DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
sys_rst_n  in  1  asynchronous active-low reset.
uart_rx  in  1  serial input; asynchronous; idles high.
rd_en  in  1  pops the FIFO head; ignored when the FIFO is empty.
clr_err  in  1  one-cycle pulse that clears all sticky error flags.
rx_data  out  DATA_BITS  FIFO head (show-ahead); valid only while rx_empty=0.
rx_empty  out  1  FIFO empty.
rx_full  out  1  FIFO full.
fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
frame_err  out  1  sticky: a stop bit was sampled low.
parity_err  out  1  sticky: parity mismatch.
overrun  out  1  sticky: a character arrived while the FIFO was full and was dropped.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: sys_rst_n low forces the following, asynchronously:
  - state = IDLE; bit counter and shift register cleared.
  - FIFO pointers = 0, so rx_empty=1, rx_full=0, fifo_count=0, rx_data=0.
  - all error flags = 0, busy=0.
  - both synchroniser flops = 1.
- A reset in the middle of a frame discards the partial character. After release, the receiver waits for a fresh falling edge.
- Input synchroniser: uart_rx passes through a 2-flop synchroniser to give rx_s. All sampling uses rx_s, so there are 2 cycles of input latency.
- Baud counter: cnt counts 0..CLKS_PER_BIT-1 and restarts on every state change.
- IDLE: when rx_s=0, go to START with cnt=0.
- START: at cnt = CLKS_PER_BIT/2 - 1 (integer division), sample rx_s.
  - Sample 0: go to DATA with cnt=0. All later samples land at mid-bit.
  - Sample 1: glitch; return to IDLE, no flag set.
- DATA: at cnt = CLKS_PER_BIT-1, shift rx_s into the shift register LSB first.
  - After DATA_BITS samples, go to PARITY if PARITY != 0, otherwise go to STOP.
- PARITY: sample at the end of the bit period.
  - Even parity: XOR of data bits and parity bit must be 0.
  - Odd parity: that XOR must be 1.
  - On mismatch, set a local perr bit.
- STOP: sample at the end of the bit period, STOP_BITS times.
  - Any low stop sample sets frame_err and moves to BREAK_WAIT once the stop bits are done.
  - Otherwise, on the cycle of the final stop sample:
    - If perr=0 and the FIFO is not full (or is full with rd_en high in that same cycle), push the character and return to IDLE.
    - If perr=1, set parity_err, drop the character, and return to IDLE.
    - If the FIFO is full with no pop, set overrun, drop the character, and return to IDLE.
- BREAK_WAIT: hold until rx_s=1, then go to IDLE. This prevents a line break from being read as a stream of start bits. No data is pushed.
- Push latency: rx_empty falls and rx_data is valid on the clock edge that follows the push cycle.
- FIFO pop: rd_en high while rx_empty=0 advances the read pointer on that edge. rx_data shows the next entry in the following cycle. Pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop:
  - fifo_count is unchanged.
  - On a full FIFO the push is accepted and no overrun is flagged.
  - On an empty FIFO the pop is ignored and the push is accepted.
- Error flags: once set they hold until clr_err. If clr_err and a new error occur in the same cycle, the set wins.

Test Plan:
1. Defaults (8N1, 2604). Reset for 1302 cycles, then send frames A5, E7, 24 with 1302 idle cycles between them. Required: fifo_count goes 1→2→3; rx_data=A5; pops return A5, E7, 24 in order; rx_empty=1 after the third pop; all error flags=0.
2. Glitch: drive uart_rx low for 500 cycles, then high. Required: state returns to IDLE at START mid-sample; no push; busy falls; no flags set.
3. Frame error: send A5 with the stop bit 0, then hold the line low for 3 bit-times. Required: frame_err=1, no push, busy stays high until uart_rx returns high. A following 3C is received correctly. clr_err clears frame_err.
4. Parity: set PARITY=1 and send 0x07 with parity bit 1 (correct). Required: pushed, parity_err=0. Send 0x07 with parity bit 0. Required: parity_err=1, fifo_count unchanged.
5. Overrun and wrap: with FIFO_DEPTH=4, send 11, 22, 33, 44, 55 with no pops. Required: rx_full=1, overrun=1, contents 11..44. Pop 2, send 66 and 77. Required: read order 33, 44, 66, 77 across the pointer wrap.
6. Full plus pop: with the FIFO full, pulse rd_en on the exact final stop-sample cycle. Required: push accepted, count stays 4, overrun=0. Separately, assert sys_rst_n low during DATA bit 4. Required: all outputs return to reset values, and the next complete frame is received correctly.
